// File: rtl/cpu_thread_sched.sv
// Round-robin hardware thread scheduler: picks the next ready thread, restores its
// context, lets it run until it yields, then saves its context and picks again.
//
// state  | meaning
// SELECT | search ready bits after thread_num (wrapping, current checked last)
// LOAD   | load_en: restore the selected thread's context
// RUN    | thread_active: CPU executes for thread_num until switch_req
// SAVE   | save_en: store context; clear ready[thread_num] unless keep latched
module cpu_thread_sched #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [N_THREADS-1:0]     ready_set,
    input  logic                     switch_req,
    input  logic                     switch_keep_ready,
    output logic [N_THREADS_MSB:0]   thread_num,
    output logic                     load_en,
    output logic                     save_en,
    output logic                     thread_active,
    output logic [N_THREADS-1:0]     ready,
    output logic                     idle
);

    localparam int THREAD_W = N_THREADS_MSB + 1;

    typedef enum logic [1:0] {
        ST_SELECT,
        ST_LOAD,
        ST_RUN,
        ST_SAVE
    } state_t;

    state_t                 state_q, state_d;
    logic [N_THREADS_MSB:0] thread_num_q, thread_num_d;
    logic [N_THREADS-1:0]   ready_q, ready_d;
    logic                   keep_q, keep_d;
    logic [N_THREADS_MSB:0] next_thread;
    logic [N_THREADS_MSB:0] cand;
    logic                   found;

    // Offsets 1..N_THREADS put the current thread last in the search order.
    always_comb begin
        found       = 1'b0;
        next_thread = thread_num_q;
        cand        = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            cand = THREAD_W'((int'(thread_num_q) + i) % N_THREADS);
            if (!found && ready_q[cand]) begin
                found       = 1'b1;
                next_thread = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        thread_num_d = thread_num_q;
        keep_d       = keep_q;
        ready_d      = ready_q;
        case (state_q)
            ST_SELECT: begin
                if (found) begin
                    thread_num_d = next_thread;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (switch_req) begin
                    keep_d  = switch_keep_ready;
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                if (!keep_q) begin
                    ready_d[thread_num_q] = 1'b0;
                end
                state_d = ST_SELECT;
            end
            default: state_d = ST_SELECT;
        endcase
        // A new ready pulse beats the SAVE clear of the same thread.
        ready_d = ready_d | ready_set;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_SELECT;
            thread_num_q <= '0;
            ready_q      <= '0;
            keep_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            thread_num_q <= thread_num_d;
            ready_q      <= ready_d;
            keep_q       <= keep_d;
        end
    end

    assign thread_num    = thread_num_q;
    assign ready         = ready_q;
    assign load_en       = (state_q == ST_LOAD);
    assign save_en       = (state_q == ST_SAVE);
    assign thread_active = (state_q == ST_RUN);
    assign idle          = (state_q == ST_SELECT) && (ready_q == '0);

endmodule
